// File: rtl/field_op_sequencer.sv
// Microcode sequencer: walks a 16-entry program and issues one field-arithmetic
// command per entry, waiting for the matching completion pulse before moving on.
module field_op_sequencer #(
    parameter logic [3:0]  OP_MUL  = 4'h1,
    parameter logic [3:0]  OP_SQR  = 4'h2,
    parameter logic [3:0]  OP_RED  = 4'h3,
    parameter logic [3:0]  OP_SWAP = 4'h4,
    parameter logic [3:0]  OP_XOR  = 4'h5,
    parameter logic [11:0] TIMEOUT = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [15:0] prog_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  pc,
    output logic [3:0]  b_command,
    output logic [2:0]  start_addr,
    output logic [2:0]  write_addr,
    output logic [1:0]  numbr_of_chunk,
    output logic        select_Ram_C_Or_D,
    output logic        select_Ram_A_Or_B,
    input  logic        interupt_mul,
    input  logic        interupt_sqr,
    input  logic        interupt_red,
    input  logic        interupt_swap,
    input  logic        interupt_Xor
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, GAP} state_t;

    typedef struct packed {
        logic       last;
        logic [2:0] op;
        logic [2:0] sa;
        logic [2:0] wa;
        logic [1:0] chunk;
        logic       sel_cd;
        logic       sel_ab;
    } instr_t;

    state_t      state, nxt;
    instr_t      mem [16];
    instr_t      ir;
    logic [11:0] cnt;
    logic [4:0]  op_sel, irq;
    logic [3:0]  cmd;
    logic        op_ok, hit, stray, fin, fault;
    logic [1:0]  unused_rsvd;

    assign unused_rsvd = prog_data[1:0];
    assign irq = {interupt_Xor, interupt_swap, interupt_red, interupt_sqr, interupt_mul};

    // One-hot of the interrupt the current op expects; zero for NOP/illegal.
    always_comb begin
        op_sel = 5'b0;
        cmd    = 4'h0;
        case (ir.op)
            3'd1: begin op_sel = 5'b00001; cmd = OP_MUL;  end
            3'd2: begin op_sel = 5'b00010; cmd = OP_SQR;  end
            3'd3: begin op_sel = 5'b00100; cmd = OP_RED;  end
            3'd4: begin op_sel = 5'b01000; cmd = OP_SWAP; end
            3'd5: begin op_sel = 5'b10000; cmd = OP_XOR;  end
            default: ;
        endcase
    end

    assign op_ok = |op_sel;
    assign hit   = |(irq & op_sel);
    assign stray = |(irq & ~op_sel);

    always_comb begin
        nxt               = state;
        fin               = 1'b0;
        fault             = 1'b0;
        b_command         = 4'h0;
        start_addr        = 3'd0;
        write_addr        = 3'd0;
        numbr_of_chunk    = 2'd0;
        select_Ram_C_Or_D = 1'b0;
        select_Ram_A_Or_B = 1'b0;
        if ((state == ISSUE || state == WAIT) && op_ok) begin
            b_command         = cmd;
            start_addr        = ir.sa;
            write_addr        = ir.wa;
            numbr_of_chunk    = ir.chunk;
            select_Ram_C_Or_D = ir.sel_cd;
            select_Ram_A_Or_B = ir.sel_ab;
        end
        case (state)
            IDLE:  if (start) nxt = FETCH;
            FETCH: nxt = ISSUE;
            ISSUE: begin
                if (ir.op == 3'd0) nxt = GAP;
                else if (op_ok)    nxt = WAIT;
                else begin fault = 1'b1; nxt = IDLE; end
            end
            // A stray pulse outranks the expected one; completion outranks timeout.
            WAIT: begin
                if (stray)                             begin fault = 1'b1; nxt = IDLE; end
                else if (hit)                          nxt = GAP;
                else if (cnt == TIMEOUT - 12'd1)       begin fault = 1'b1; nxt = IDLE; end
            end
            GAP: begin
                if (ir.last || pc == 4'd15) begin fin = 1'b1; nxt = IDLE; end
                else nxt = FETCH;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
            cnt   <= 12'd0;
            ir    <= '0;
        end else begin
            state <= nxt;
            done  <= fin;
            case (state)
                IDLE: if (start) begin
                    pc    <= 4'd0;
                    error <= 1'b0;
                    busy  <= 1'b1;
                end
                FETCH: ir <= mem[pc];
                ISSUE: cnt <= 12'd0;
                WAIT:  cnt <= cnt + 12'd1;
                GAP:   if (!fin) pc <= pc + 4'd1;
                default: ;
            endcase
            if (fault) error <= 1'b1;
            if (fault || fin) busy <= 1'b0;
        end
    end

    // Program store survives reset; it is only locked while a program runs.
    always_ff @(posedge clk) begin
        if (rst_n && prog_we && !busy) mem[prog_addr] <= prog_data[15:2];
    end
endmodule

// File: doc/field_op_sequencer.md
FIELD_OP_SEQUENCER -- requirements
Module: field_op_sequencer

Interface
REQ-001 Parameters: OP_MUL default 4'h1 (MUL command code); OP_SQR default 4'h2; OP_RED default 4'h3; OP_SWAP default 4'h4; OP_XOR default 4'h5; TIMEOUT default 12'hFFF (max WAIT cycles).
REQ-002 Ports (clock and reset first):
clk  in  1  single clock, rising edge.
rst_n  in  1  synchronous reset, active-low.
prog_we  in  1  program-memory write strobe.
prog_addr  in  4  program-memory word address.
prog_data  in  16  microinstruction word.
start  in  1  run program from entry 0.
busy  out  1  program executing.
done  out  1  one-cycle pulse on normal completion.
error  out  1  sticky fault flag.
pc  out  4  current instruction index.
b_command  out  4  command code to field-arithmetic datapath.
start_addr  out  3  operand read address.
write_addr  out  3  result write address (swap).
numbr_of_chunk  out  2  chunk count (swap).
select_Ram_C_Or_D  out  1  swap destination select.
select_Ram_A_Or_B  out  1  swap source select.
interupt_mul, interupt_sqr, interupt_red, interupt_swap, interupt_Xor  in  1 each  operation-complete pulses from datapath.
REQ-003 One clock; reset is synchronous and active-low.

Function
REQ-004 Program memory: 16 x 16 bits, written when prog_we=1 and busy=0; writes while busy ignored.
REQ-005 Word format: [15] last; [14:12] op (0 NOP, 1 MUL, 2 SQR, 3 RED, 4 SWAP, 5 XOR, 6-7 illegal); [11:9] start_addr; [8:6] write_addr; [5:4] numbr_of_chunk; [3] select_Ram_C_Or_D; [2] select_Ram_A_Or_B; [1:0] reserved, ignored.
REQ-006 States: IDLE, FETCH, ISSUE, WAIT, GAP.
REQ-007 IDLE: start=1 -> pc=0, error cleared, busy=1, go to FETCH; start sampled only in IDLE.
REQ-008 FETCH (1 cycle): word at pc latched into instruction register; go to ISSUE.
REQ-009 ISSUE: op 1-5 -> b_command = matching OP_* parameter, operand fields driven from instruction register, timeout counter cleared, go to WAIT; op 0 -> no command, go to GAP; op 6-7 -> error=1, go to IDLE.
REQ-010 b_command valid 2 cycles after start is sampled (cycle N start, N+1 FETCH, N+2 ISSUE).
REQ-011 b_command and all operand fields held stable from ISSUE through the last WAIT cycle.
REQ-012 WAIT: the interrupt matching current op -> GAP; any non-matching interrupt -> error=1, go to IDLE; matching and non-matching same cycle -> error wins.
REQ-013 WAIT counter increments each cycle; reaching TIMEOUT with no interrupt -> error=1, go to IDLE.
REQ-014 GAP (1 cycle): b_command=4'h0; if last=1 or pc=15 -> done=1 for one cycle, busy=0, go to IDLE; else pc=pc+1, go to FETCH.
REQ-015 pc never wraps: entry 15 is always terminal regardless of last bit.
REQ-016 Interrupts arriving in IDLE, FETCH, ISSUE or GAP are ignored.
REQ-017 b_command=4'h0 and operand fields 0 in IDLE, FETCH, GAP and on any error exit.
REQ-018 error remains 1 until next accepted start or reset; done never asserted on an error exit.

Reset
REQ-019 rst_n=0 at a clock edge: state=IDLE, pc=0, busy=0, done=0, error=0, b_command=4'h0, start_addr=0, write_addr=0, numbr_of_chunk=0, both selects 0, timeout counter 0.
REQ-020 Reset mid-program aborts immediately with no done pulse; program memory contents are retained, not cleared.
REQ-021 Reset overrides start, prog_we and interrupts in the same cycle.

Verification
REQ-022 Program {0:MUL sa=2, 1:RED sa=2 last}; start at cycle 0; interupt_mul at cycle 5 -> b_command=1 cycles 2-5, 0 cycle 6, b_command=3 from cycle 8; interupt_red -> done pulse next cycle, busy=0.
REQ-023 Entry 0 = SWAP sa=1 wa=4 chunk=2 C/D=1 A/B=0 last -> outputs 3'd1/3'd4/2'd2/1/0 held until interupt_swap; done follows GAP.
REQ-024 Entry 0 = SQR; in WAIT assert interupt_Xor -> error=1, next state IDLE, b_command=0, no done; next start clears error.
REQ-025 TIMEOUT=8, entry 0 = MUL, no interrupt -> error=1 after 8 WAIT cycles, busy=0.
REQ-026 All 16 entries NOP, last=0 -> runs pc 0..15, done at entry 15, no b_command issued; prog_we during run leaves memory unchanged.
REQ-027 rst_n=0 during WAIT of entry 3 -> all outputs at reset values next cycle; restart reruns unchanged program from entry 0.
